// File: rtl/mem_pkg.sv
// Shared sizing constants for the byte-addressed data memory.
// The access width is fixed at 8 bytes; storage size and port widths default from here.
package mem_pkg;
  localparam int DATA_W         = 64;
  localparam int ADDR_W         = 64;
  localparam int DEPTH          = 256;
  localparam int BYTES_PER_WORD = 8;
endpackage

// File: rtl/memory.sv
// Byte-addressed memory with unaligned, wrapping 8-byte little-endian accesses.
// Registered read (1-cycle latency, read-before-write), async active-low clear of all state.
module memory #(
  parameter int DATA_W = mem_pkg::DATA_W,
  parameter int ADDR_W = mem_pkg::ADDR_W,
  parameter int DEPTH  = mem_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] addr,
  input  logic              mem_read,
  input  logic              mem_write,
  output logic [DATA_W-1:0] data_out
);
  import mem_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int NB = BYTES_PER_WORD;
  localparam int WW = NB * 8;

  logic [7:0]        mem_q [DEPTH];
  logic [DATA_W-1:0] data_out_q;
  logic [AW-1:0]     lane_addr [NB];
  logic [WW-1:0]     rd_word;
  logic [WW-1:0]     wr_word;

  // Each lane's byte address wraps naturally in the AW-bit adder.
  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      assign lane_addr[gi]          = addr[AW-1:0] + AW'(gi);
      assign rd_word[gi*8 +: 8]     = mem_q[lane_addr[gi]];
    end
    if (ADDR_W > AW) begin : g_unused_addr
      logic unused_addr_bits;
      assign unused_addr_bits = ^addr[ADDR_W-1:AW];
    end
  endgenerate

  assign wr_word = WW'(data_in);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      data_out_q <= '0;
    end else begin
      // rd_word samples the pre-edge contents, giving old data on a same-edge write.
      if (mem_read) data_out_q <= DATA_W'(rd_word);
      if (mem_write) begin
        for (int k = 0; k < NB; k++) mem_q[lane_addr[k]] <= wr_word[k*8 +: 8];
      end
    end
  end

  assign data_out = data_out_q;
endmodule

// File: tb/tb_memory.sv
// Randomized self-checking bench for memory against a byte-array reference model.
module tb_memory;
  localparam int DATA_W = mem_pkg::DATA_W;
  localparam int ADDR_W = mem_pkg::ADDR_W;
  localparam int DEPTH  = mem_pkg::DEPTH;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] data_in;
  logic [ADDR_W-1:0] addr;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] data_out;

  int checks = 0;
  int errors = 0;

  logic [7:0]  model [DEPTH];
  logic [63:0] exp_out;

  memory #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .addr(addr),
    .mem_read(mem_read), .mem_write(mem_write), .data_out(data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %016h expected %016h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model_read(input logic [ADDR_W-1:0] a);
    logic [63:0] w;
    int base;
    base = int'(a % DEPTH);
    for (int k = 0; k < 8; k++) w[8*k +: 8] = model[(base + k) % DEPTH];
    return w;
  endfunction

  task automatic model_write(input logic [ADDR_W-1:0] a, input logic [63:0] d);
    int base;
    base = int'(a % DEPTH);
    for (int k = 0; k < 8; k++) model[(base + k) % DEPTH] = d[8*k +: 8];
  endtask

  // Called on a falling edge; drives one access, clocks it, checks at the next falling edge.
  task automatic access(input string tag, input logic rd, input logic wr,
                        input logic [ADDR_W-1:0] a, input logic [63:0] d);
    mem_read  = rd;
    mem_write = wr;
    addr      = a;
    data_in   = d;
    @(posedge clk);
    if (rd) exp_out = model_read(a);
    if (wr) model_write(a, d);
    @(negedge clk);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    check(tag, data_out, exp_out);
    $display("access %-10s rd=%0b wr=%0b addr=%0d din=%016h dout=%016h", tag, rd, wr, a, d, data_out);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
    exp_out   = '0;
    rst_n     = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    addr      = '0;
    data_in   = '0;
    #1 check("rst_dout_async", data_out, 64'h0);

    // Accesses during reset are ignored.
    @(negedge clk);
    mem_read = 1'b1; mem_write = 1'b1; addr = '0; data_in = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    check("rst_ignore_rd", data_out, 64'h0);
    mem_read = 1'b0; mem_write = 1'b0;
    rst_n = 1'b1;

    // First edge after release is a normal access; all bytes read back zero.
    access("rst_rd0", 1, 0, 0, 0);
    for (int a = 8; a < DEPTH; a += 8) access("rst_zero", 1, 0, a, 0);

    // Write then read, aligned and offset by one.
    access("wr8", 0, 1, 8, 64'h0123_4567_89AB_CDEF);
    access("rd8", 1, 0, 8, 0);
    check("rd8_const", data_out, 64'h0123_4567_89AB_CDEF);
    access("rd9", 1, 0, 9, 0);
    check("rd9_const", data_out, 64'h0001_2345_6789_ABCD);

    // Read-enable low holds data_out even while writing.
    access("hold", 0, 1, 40, 64'hDEAD_BEEF_0000_1111);
    check("hold_const", data_out, 64'h0001_2345_6789_ABCD);

    // Sequential PC+4 fetch over preloaded random words.
    for (int a = 0; a < 136; a += 8) access("preload", 0, 1, a, {$urandom, $urandom});
    for (int a = 0; a <= 124; a += 4) access("fetch", 1, 0, a, 0);
    for (int a = 0; a < 136; a += 8) access("unchanged", 1, 0, a, 0);

    // Wrap around the top of storage, plus upper address bits ignored.
    for (int a = 0; a < 8; a++) model[a] = 8'h00;
    access("clr_lo", 0, 1, 0, 0);
    access("wr_wrap", 0, 1, DEPTH - 3, 64'h1122_3344_5566_7788);
    access("rd_wrap0", 1, 0, 0, 0);
    check("wrap0_const", data_out, 64'h0000_0011_2233_4455);
    access("rd_wrap", 1, 0, DEPTH - 3, 0);
    check("wrap_const", data_out, 64'h1122_3344_5566_7788);
    access("rd_alias", 1, 0, DEPTH - 3 + DEPTH, 0);
    check("alias_const", data_out, 64'h1122_3344_5566_7788);

    // Same-edge read and write returns old data.
    access("wr_aa", 0, 1, 16, 64'hAA);
    access("rdwr_bb", 1, 1, 16, 64'hBB);
    check("rdwr_old", data_out, 64'hAA);
    access("rd_bb", 1, 0, 16, 0);
    check("rd_new", data_out, 64'hBB);

    // Random traffic with full-width addresses.
    for (int n = 0; n < 400; n++)
      access("rand", 1'($urandom), 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom});

    // Asynchronous reset between edges, with a write attempted while held.
    access("pre_rst", 1, 0, 8, 0);
    check("pre_rst_nz", 64'(data_out != 0), 64'h1);
    #1 rst_n = 1'b0;
    #1 check("async_clear", data_out, 64'h0);
    mem_write = 1'b1; addr = 8; data_in = 64'h5A5A_5A5A_5A5A_5A5A;
    @(posedge clk);
    #1 check("rst_hold", data_out, 64'h0);
    @(negedge clk);
    mem_write = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
    exp_out = '0;
    access("post_rst8", 1, 0, 8, 0);
    access("post_rst16", 1, 0, 16, 0);
    access("post_rst_w", 1, 0, DEPTH - 3, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/memory.md
MEMORY -- requirements
Module: memory

Interface
REQ-001 Parameter DATA_W, default 64, data word width in bits.
REQ-002 Parameter ADDR_W, default 64, byte-address width in bits.
REQ-003 Parameter DEPTH, default 256, storage size in bytes; must be a power of two and at least 8.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 data_in  input  DATA_W  write data.
REQ-007 addr  input  ADDR_W  byte address of the first byte of the access.
REQ-008 mem_read  input  1  read enable.
REQ-009 mem_write  input  1  write enable.
REQ-010 data_out  output  DATA_W  registered read data.

Function
REQ-011 Storage SHALL be DEPTH bytes, byte-addressed; an access covers 8 consecutive bytes, addr through addr+7.
REQ-012 Only addr[log2(DEPTH)-1:0] SHALL be used; upper address bits are ignored.
REQ-013 Byte offsets addr+k (k=0..7) SHALL wrap modulo DEPTH, so an access starting at DEPTH-3 covers bytes DEPTH-3..DEPTH-1 then 0..4.
REQ-014 No alignment is required; any byte address, including non-multiples of 4 or 8, is legal.
REQ-015 Byte ordering SHALL be little-endian: byte addr+k maps to data bits [8k+7:8k].
REQ-016 When mem_write=1, the rising edge SHALL store all 8 bytes of data_in; no byte enables.
REQ-017 When mem_read=1, the rising edge SHALL load data_out with the 8 bytes at addr; read latency is exactly 1 cycle.
REQ-018 When mem_read=0, data_out SHALL hold its previous value.
REQ-019 When mem_read=1 and mem_write=1 on the same edge, data_out SHALL return the pre-write (old) contents, read-before-write, and the write SHALL still complete.
REQ-020 When mem_write=0, the contents SHALL never change.
REQ-021 No handshake exists; a new access is accepted every cycle.

Reset
REQ-022 While rst_n=0, data_out SHALL be 0 and every storage byte SHALL be 0, immediately and independent of clk.
REQ-023 Reads and writes SHALL be ignored while rst_n=0.
REQ-024 If rst_n is asserted mid-operation, any write on that edge is discarded.
REQ-025 After rst_n deasserts, the first rising edge SHALL perform a normal access.

Structure
REQ-026 DATA_W, ADDR_W, DEPTH and the bytes-per-word constant (8) SHALL live in a shared package, mem_pkg.
REQ-027 No sub-module is needed; the byte-offset wrap adders and the lane mux/demux SHALL be implemented inline in memory.

Verification
REQ-028 Reset: hold rst_n=0, then read addr 0 -> data_out=0 and all bytes read back as 0.
REQ-029 Write then read: write 0x0123456789ABCDEF at addr 8, then read addr 8 -> data_out=0x0123456789ABCDEF one cycle later; read addr 9 -> 0x000123456789ABCD.
REQ-030 Sequential fetch: preload words, then read addr=0,4,8,...,124 (PC+4 stepping) with mem_read=1, mem_write=0 -> each data_out matches the model one cycle after its address; contents unchanged.
REQ-031 Wrap: write 0x1122334455667788 at addr DEPTH-3=253, then read addr 0 -> low 5 bytes read 0x0000001122334455 pattern per little-endian model; also read addr 253+DEPTH -> identical to addr 253.
REQ-032 Simultaneous access: with addr 16 holding 0xAA, assert read and write of 0xBB on the same edge -> data_out=0xAA, then the next read gives 0xBB.
REQ-033 Async reset mid-run: pull rst_n low between edges -> data_out becomes 0 before the next clk edge; a write attempted during reset leaves memory 0.
